// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC sample scheduler.
// The DAC_SCHED_SIGNED_IN_EN build option is handled in dac_sample_scheduler.
package dac_sched_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  typedef enum logic {WAIT_LO, WAIT_HI} asm_state_t;
  typedef enum logic {PREFILL, PLAY} play_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle. Reset discards all contents.
module sample_fifo
  import dac_sched_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic                CLK_IN,
  input  logic                RESETN_IN,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [SAMPLE_W-1:0] din_i,
  output logic [SAMPLE_W-1:0] head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [AW:0]         count_o
);

  localparam int DEPTH = 1 << AW;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RESETN_IN) begin
    if (!RESETN_IN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge CLK_IN) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Pairs UART bytes into 16-bit samples and releases one per sample tick.
// Build option DAC_SCHED_SIGNED_IN_EN: convert two's complement input to offset binary.
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int SAMPLE_RATE  = 11_025,
  parameter int FIFO_AW      = 4,
  parameter int BYTE_TIMEOUT = 2048
) (
  input  logic                CLK_IN,
  input  logic                RESETN_IN,
  input  logic [7:0]          RX_DATA_i,
  input  logic                RX_VALID_i,
  input  logic                PLAY_EN_i,
  output logic [SAMPLE_W-1:0] SAMPLE_o,
  output logic                SAMPLE_STB_o,
  output logic [FIFO_AW:0]    FILL_o,
  output logic                UNDERRUN_o,
  output logic                OVERFLOW_o
);

  localparam int DIV   = CLK_FREQ / SAMPLE_RATE;
  localparam int DIV_W = $clog2(DIV);
  localparam int TMO_W = $clog2(BYTE_TIMEOUT);
  localparam int DEPTH = 1 << FIFO_AW;

  asm_state_t          asm_q, asm_d;
  play_state_t         play_q, play_d;
  logic [7:0]          lo_q, lo_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                stb_q, stb_d;
  logic                underrun_q, underrun_d;
  logic                overflow_q, overflow_d;

  logic                push, pop, tick;
  logic [SAMPLE_W-1:0] push_data, fifo_head;
  logic                fifo_full, fifo_empty;
  logic [FIFO_AW:0]    fifo_count;

`ifdef DAC_SCHED_SIGNED_IN_EN
  assign push_data = {~RX_DATA_i[7], RX_DATA_i[6:0], lo_q};
`else
  assign push_data = {RX_DATA_i, lo_q};
`endif

  always_comb begin
    asm_d = asm_q;
    lo_d  = lo_q;
    tmo_d = tmo_q;
    push  = 1'b0;
    case (asm_q)
      WAIT_LO: if (RX_VALID_i) begin
        lo_d  = RX_DATA_i;
        tmo_d = '0;
        asm_d = WAIT_HI;
      end
      WAIT_HI: if (RX_VALID_i) begin
        push  = 1'b1;
        asm_d = WAIT_LO;
      end else if (tmo_q == TMO_W'(BYTE_TIMEOUT - 1)) begin
        asm_d = WAIT_LO;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
      default: asm_d = WAIT_LO;
    endcase
  end

  assign tick  = (div_q == DIV_W'(DIV - 1));
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  // Disabling playback overrides everything and parks the DAC at midscale.
  always_comb begin
    play_d     = play_q;
    sample_d   = sample_q;
    stb_d      = 1'b0;
    underrun_d = 1'b0;
    pop        = 1'b0;
    if (!PLAY_EN_i) begin
      play_d   = PREFILL;
      sample_d = MIDSCALE;
    end else begin
      case (play_q)
        PREFILL: if (fifo_count >= (FIFO_AW+1)'(DEPTH / 2)) play_d = PLAY;
        PLAY: if (tick) begin
          stb_d = 1'b1;
          if (!fifo_empty) begin
            pop      = 1'b1;
            sample_d = fifo_head;
          end else begin
            underrun_d = 1'b1;
            play_d     = PREFILL;
          end
        end
        default: play_d = PREFILL;
      endcase
    end
  end

  assign overflow_d = push && fifo_full && !pop;

  always_ff @(posedge CLK_IN or negedge RESETN_IN) begin
    if (!RESETN_IN) begin
      asm_q      <= WAIT_LO;
      lo_q       <= '0;
      tmo_q      <= '0;
      div_q      <= '0;
      play_q     <= PREFILL;
      sample_q   <= MIDSCALE;
      stb_q      <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      lo_q       <= lo_d;
      tmo_q      <= tmo_d;
      div_q      <= div_d;
      play_q     <= play_d;
      sample_q   <= sample_d;
      stb_q      <= stb_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  sample_fifo #(.AW(FIFO_AW)) u_fifo (
    .CLK_IN    (CLK_IN),
    .RESETN_IN (RESETN_IN),
    .push_i    (push),
    .pop_i     (pop),
    .din_i     (push_data),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign SAMPLE_o     = sample_q;
  assign SAMPLE_STB_o = stb_q;
  assign FILL_o       = fifo_count;
  assign UNDERRUN_o   = underrun_q;
  assign OVERFLOW_o   = overflow_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler with a sample scoreboard.
// Expected samples honour DAC_SCHED_SIGNED_IN_EN when it is defined.
module tb_dac_sample_scheduler;

  localparam int DIV = 12_000_000 / 11_025;

  logic        CLK_IN = 1'b0;
  logic        RESETN_IN;
  logic [7:0]  RX_DATA_i;
  logic        RX_VALID_i;
  logic        PLAY_EN_i;
  logic [15:0] SAMPLE_o;
  logic        SAMPLE_STB_o;
  logic [4:0]  FILL_o;
  logic        UNDERRUN_o;
  logic        OVERFLOW_o;

  dac_sample_scheduler dut (
    .CLK_IN       (CLK_IN),
    .RESETN_IN    (RESETN_IN),
    .RX_DATA_i    (RX_DATA_i),
    .RX_VALID_i   (RX_VALID_i),
    .PLAY_EN_i    (PLAY_EN_i),
    .SAMPLE_o     (SAMPLE_o),
    .SAMPLE_STB_o (SAMPLE_STB_o),
    .FILL_o       (FILL_o),
    .UNDERRUN_o   (UNDERRUN_o),
    .OVERFLOW_o   (OVERFLOW_o)
  );

  always #5 CLK_IN = ~CLK_IN;

  int cyc;
  always @(posedge CLK_IN or negedge RESETN_IN) begin
    if (!RESETN_IN) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  logic [15:0] exp_q[$];
  logic [15:0] last_exp = 16'h8000;
  logic [15:0] mon_e;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_IN);
    #1;
  endtask

  function automatic logic [15:0] model(input logic [7:0] lo, input logic [7:0] hi);
    logic [15:0] s;
    s = {hi, lo};
`ifdef DAC_SCHED_SIGNED_IN_EN
    s[15] = ~s[15];
`endif
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    RX_DATA_i  = b;
    RX_VALID_i = 1'b1;
    step();
    RX_VALID_i = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] lo, input logic [7:0] hi);
    send_byte(lo);
    send_byte(hi);
    exp_q.push_back(model(lo, hi));
  endtask

  task automatic wait_stb(input string tag, output int at);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (SAMPLE_STB_o !== 1'b1 && n < 1300);
    chk(tag, SAMPLE_STB_o, 1);
    at = cyc;
  endtask

  // Scoreboard: each strobe consumes one expected sample, or is an underrun when none is owed.
  always @(negedge CLK_IN) begin
    if (RESETN_IN === 1'b1 && SAMPLE_STB_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("underrun_flag", UNDERRUN_o, 1);
        chk("underrun_hold", SAMPLE_o, last_exp);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sample_order", SAMPLE_o, mon_e);
        chk("no_underrun", UNDERRUN_o, 0);
        last_exp = mon_e;
      end
    end
  end

  logic [15:0] fill7 [7] = '{16'h6100, 16'h9003, 16'h0029, 16'h1234,
                             16'hABCD, 16'h5555, 16'h0FF0};

  initial begin
    int t0, t1, t2, t3, t, n;
    bit got_ur;
    logic [15:0] exp_s;

    RX_DATA_i  = 8'h00;
    RX_VALID_i = 1'b0;
    PLAY_EN_i  = 1'b0;
    RESETN_IN  = 1'b0;
    repeat (3) @(posedge CLK_IN);
    #1;
    chk("rst_sample", SAMPLE_o, 16'h8000);
    chk("rst_fill", FILL_o, 0);
    chk("rst_stb", SAMPLE_STB_o, 0);
    chk("rst_underrun", UNDERRUN_o, 0);
    chk("rst_overflow", OVERFLOW_o, 0);

    RESETN_IN = 1'b1;
    PLAY_EN_i = 1'b1;
    send_pair(8'h00, 8'h40);
    step();
    chk("fill_one", FILL_o, 1);
    chk("no_stb_prefill", SAMPLE_STB_o, 0);
    for (int i = 0; i < 7; i++) send_pair(fill7[i][7:0], fill7[i][15:8]);
    chk("fill_eight", FILL_o, 8);

    wait_stb("first_stb", t0);
    chk("first_tick_phase", 32'(t0 % DIV), 0);
    chk("first_sample", SAMPLE_o, model(8'h00, 8'h40));
    step();
    chk("stb_one_cycle", SAMPLE_STB_o, 0);
    wait_stb("stb2", t1);
    wait_stb("stb3", t2);
    wait_stb("stb4", t3);
    chk("spacing_1", 32'(t1 - t0), DIV);
    chk("spacing_2", 32'(t2 - t1), DIV);
    chk("spacing_3", 32'(t3 - t2), DIV);

    // Orphan low byte must be dropped by the timeout.
    send_byte(8'h03);
    repeat (2100) step();
    send_pair(8'h29, 8'h00);

    got_ur = 1'b0;
    for (int k = 0; k < 6 && !got_ur; k++) begin
      wait_stb("drain_stb", t);
      if (UNDERRUN_o === 1'b1) got_ur = 1'b1;
    end
    chk("underrun_seen", got_ur, 1);
    chk("underrun_sample", SAMPLE_o, model(8'h29, 8'h00));
    step();
    chk("underrun_one_cycle", UNDERRUN_o, 0);
    n = 0;
    repeat (1100) begin
      step();
      if (SAMPLE_STB_o === 1'b1) n++;
    end
    chk("prefill_after_underrun", n, 0);

    PLAY_EN_i = 1'b0;
    step();
    chk("disable_midscale", SAMPLE_o, 16'h8000);
    last_exp = 16'h8000;
    for (int i = 0; i < 16; i++) send_pair(8'(i * 3 + 1), 8'(8'h20 + i));
    chk("fill_full", FILL_o, 16);
    chk("no_overflow_yet", OVERFLOW_o, 0);
    send_byte(8'h77);
    send_byte(8'h66);
    chk("overflow_pulse", OVERFLOW_o, 1);
    chk("overflow_fill", FILL_o, 16);
    step();
    chk("overflow_once", OVERFLOW_o, 0);

    n = 0;
    while (cyc % DIV != 10 && n < 2000) begin step(); n++; end
    PLAY_EN_i = 1'b1;
    send_byte(8'h5A);
    n = 0;
    while (cyc % DIV != DIV - 1 && n < 2000) begin step(); n++; end
    RX_DATA_i  = 8'hA5;
    RX_VALID_i = 1'b1;
    step();
    RX_VALID_i = 1'b0;
    exp_q.push_back(model(8'h5A, 8'hA5));
    chk("pushpop_stb", SAMPLE_STB_o, 1);
    chk("pushpop_no_overflow", OVERFLOW_o, 0);
    chk("pushpop_fill", FILL_o, 16);
    step();
    chk("pushpop_no_overflow_late", OVERFLOW_o, 0);

    RESETN_IN = 1'b0;
    #1;
    chk("midrst_sample", SAMPLE_o, 16'h8000);
    chk("midrst_fill", FILL_o, 0);
    exp_q.delete();
    last_exp = 16'h8000;
    step();
    step();
    RESETN_IN = 1'b1;

    send_pair(8'h19, 8'h91);
    for (int i = 0; i < 7; i++) send_pair(fill7[i][7:0], fill7[i][15:8]);
    chk("post_rst_midscale", SAMPLE_o, 16'h8000);
`ifdef DAC_SCHED_SIGNED_IN_EN
    exp_s = 16'h1119;
`else
    exp_s = 16'h9119;
`endif
    wait_stb("signed_stb", t);
    chk("signed_sample", SAMPLE_o, exp_s);

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
- Sits between the UART byte receiver and the 16-bit audio DAC driver on the dacboard.
- Pairs received bytes into 16-bit samples, low byte first, and buffers them in a small FIFO.
- Releases one sample per sample-rate tick derived from the system clock.
- Handles prefill, underrun, overflow and byte-pair resynchronisation.

Parameters:
- CLK_FREQ, 12_000_000: system clock in Hz.
- SAMPLE_RATE, 11_025: output sample rate in Hz. The tick divider is DIV = CLK_FREQ/SAMPLE_RATE, integer-truncated (1088 at the defaults).
- FIFO_AW, 4: FIFO address width. Depth is 2**FIFO_AW = 16.
- BYTE_TIMEOUT, 2048: maximum clocks allowed between the low and high byte of one sample.

Ports:
- CLK_IN  in  1  system clock
- RESETN_IN  in  1  asynchronous, active-low reset
- RX_DATA_i  in  8  received UART byte
- RX_VALID_i  in  1  one-cycle strobe; RX_DATA_i is valid in this cycle
- PLAY_EN_i  in  1  playback enable
- SAMPLE_o  out  16  current DAC sample, registered
- SAMPLE_STB_o  out  1  one-cycle pulse each time SAMPLE_o is updated on a tick
- FILL_o  out  FIFO_AW+1  current FIFO occupancy
- UNDERRUN_o  out  1  one-cycle pulse on a tick that finds the FIFO empty while in PLAY
- OVERFLOW_o  out  1  one-cycle pulse when a completed sample is dropped because the FIFO is full

Behaviour:
- Reset: SAMPLE_o=16'h8000 (midscale); SAMPLE_STB_o, UNDERRUN_o, OVERFLOW_o = 0; FILL_o = 0; FIFO empty; assembler in WAIT_LO; player in PREFILL; divider = 0.
- A reset asserted mid-operation discards the FIFO contents and any partial byte pair immediately.
- Assembler FSM:
  - WAIT_LO: on RX_VALID_i, latch the low byte, clear the timeout counter, go to WAIT_HI.
  - WAIT_HI: on RX_VALID_i, form {RX_DATA_i, lo}, issue a push, go to WAIT_LO.
  - WAIT_HI without a byte: the timeout counter increments each clock. When it reaches BYTE_TIMEOUT-1, discard the low byte and go to WAIT_LO. No push, no flag.
- Push rules:
  - Push while FILL = depth and no pop in the same cycle: sample dropped, OVERFLOW_o pulses the following cycle.
  - Push and pop in the same cycle while full: the push is accepted.
  - Push and pop in the same cycle in any state: FILL_o is unchanged.
- Divider:
  - Free-running counter 0..DIV-1. tick=1 when the counter is at DIV-1.
  - The counter runs regardless of player state. Width is $clog2(DIV).
- Player FSM:
  - PREFILL: SAMPLE_o holds its value, no strobes. Go to PLAY when PLAY_EN_i=1 and FILL_o >= depth/2.
  - PLAY, on tick with FIFO not empty: pop; SAMPLE_o <= head; SAMPLE_STB_o=1 in the cycle after the tick.
  - PLAY, on tick with FIFO empty: SAMPLE_o holds; SAMPLE_STB_o=1 and UNDERRUN_o=1 in the cycle after the tick; go to PREFILL.
  - PLAY_EN_i=0 in any state: go to PREFILL, SAMPLE_o <= 16'h8000. FIFO contents are retained.
- Latency:
  - The first sample appears on the first tick after the prefill condition is met.
  - From a tick to the SAMPLE_o update is 1 clock.
- FIFO pointers wrap modulo depth. FILL_o is kept as a separate counter, 0..depth.

Optional Feature:
- Macro: DAC_SCHED_SIGNED_IN_EN.
- Defined: incoming samples are two's complement. Bit 15 is inverted on push to convert to offset binary.
- Undefined: samples are passed to the FIFO unchanged.
- Reset and idle value is 16'h8000 in both cases.

Decomposition:
- Package dac_sched_pkg holds:
  - SAMPLE_W=16 and MIDSCALE=16'h8000.
  - Assembler state enum {WAIT_LO, WAIT_HI}.
  - Player state enum {PREFILL, PLAY}.
- One sub-module, sample_fifo: synchronous FIFO with push/pop, full/empty, count, and the same CLK_IN/RESETN_IN.
- Assembler, divider and player stay in the top module.

Test Plan:
- Reset, then bytes 0x00,0x40 with PLAY_EN_i=1 -> FILL_o=1, no strobe. After 7 more pairs (FILL_o=8) the next tick gives SAMPLE_o=16'h4000 and SAMPLE_STB_o high for one cycle.
- Steady playback of samples 0x4000, 0x6100, 0x9003, 0x0029 -> SAMPLE_o follows this order, with exactly DIV=1088 clocks between strobes.
- Low byte 0x03, then silence for >2048 clocks, then 0x29,0x00 -> one sample 16'h0029 pushed; 0x03 is discarded.
- FIFO fill reaches 16, PLAY_EN_i=0, then one more pair -> OVERFLOW_o pulses once, FILL_o stays 16. Push coinciding with a pop while full -> accepted, no pulse.
- In PLAY, let the FIFO drain -> the next tick gives UNDERRUN_o=1 and SAMPLE_STB_o=1, SAMPLE_o holds its last value, and the player is back in PREFILL.
- With DAC_SCHED_SIGNED_IN_EN defined, send 16'h9119 -> SAMPLE_o=16'h1119. Assert RESETN_IN mid-stream -> SAMPLE_o=16'h8000 and FILL_o=0 immediately.
